// File: rtl/rv_isa_pkg.sv
// RV32I encoding constants, descriptor kinds and field packing helpers
// shared by the instruction encoder and its format packer.
package rv_isa_pkg;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0]  F7_ALT = 7'b0100000;
    localparam logic [31:0] NOP    = 32'h00000013;

    typedef enum logic [3:0] {
        K_R      = 4'd0,
        K_I_ALU  = 4'd1,
        K_LOAD   = 4'd2,
        K_STORE  = 4'd3,
        K_BRANCH = 4'd4,
        K_JAL    = 4'd5,
        K_JALR   = 4'd6,
        K_LUI    = 4'd7,
        K_AUIPC  = 4'd8,
        K_LI     = 4'd9
    } kind_e;

    typedef enum logic {S_IDLE = 1'b0, S_LI_LO = 1'b1} li_state_e;

    function automatic logic [31:0] enc_i(input logic [6:0] opc, input logic [4:0] rd,
                                          input logic [2:0] f3, input logic [4:0] rs1,
                                          input logic [11:0] imm);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_u(input logic [6:0] opc, input logic [4:0] rd,
                                          input logic [19:0] imm);
        return {imm, rd, opc};
    endfunction
endpackage

// File: rtl/rv_instr_pack.sv
// Combinational RV32I format packer with legality checks.
// LI is expanded by the caller; here it is always legal and packs to zero.
module rv_instr_pack
    import rv_isa_pkg::*;
(
    input  logic [3:0]  kind,
    input  logic [2:0]  funct3,
    input  logic        alt,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        err
);
    logic fits12, fits13, fits21, is_shift;
    logic [6:0] f7;

    // a signed value fits N bits when all bits above N-1 equal the sign bit
    assign fits12   = (imm[31:11] == '0) || (imm[31:11] == '1);
    assign fits13   = (imm[31:12] == '0) || (imm[31:12] == '1);
    assign fits21   = (imm[31:20] == '0) || (imm[31:20] == '1);
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
    assign f7       = alt ? F7_ALT : 7'b0;

    always_comb begin
        word = '0;
        err  = 1'b0;
        case (kind)
            K_R: begin
                word = {f7, rs2, rs1, funct3, rd, OPC_OP};
                err  = alt && (funct3 != 3'b000) && (funct3 != 3'b101);
            end
            K_I_ALU: begin
                if (is_shift) begin
                    word = enc_i(OPC_OP_IMM, rd, funct3, rs1, {f7, imm[4:0]});
                    err  = (imm[31:5] != '0);
                end else begin
                    word = enc_i(OPC_OP_IMM, rd, funct3, rs1, imm[11:0]);
                    err  = !fits12;
                end
                if (alt && funct3 != 3'b101) err = 1'b1;
            end
            K_LOAD: begin
                word = enc_i(OPC_LOAD, rd, funct3, rs1, imm[11:0]);
                err  = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) || !fits12;
            end
            K_STORE: begin
                word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
                err  = (funct3 > 3'b010) || !fits12;
            end
            K_BRANCH: begin
                word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
                err  = (funct3 == 3'b010) || (funct3 == 3'b011) || imm[0] || !fits13;
            end
            K_JAL: begin
                word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
                err  = imm[0] || !fits21;
            end
            K_JALR: begin
                word = enc_i(OPC_JALR, rd, 3'b000, rs1, imm[11:0]);
                err  = (funct3 != 3'b000) || !fits12;
            end
            K_LUI: begin
                word = enc_u(OPC_LUI, rd, imm[19:0]);
                err  = (imm[31:20] != '0);
            end
            K_AUIPC: begin
                word = enc_u(OPC_AUIPC, rd, imm[19:0]);
                err  = (imm[31:20] != '0);
            end
            K_LI:    err = 1'b0;
            default: err = 1'b1;
        endcase
    end
endmodule

// File: rtl/rv_instr_encoder.sv
// Streaming RV32I encoder: valid/ready descriptor in, one registered word out,
// LI expanded to LUI+ADDI. Define INSTR_ENC_STATS_EN for word/error counters.
module rv_instr_encoder
    import rv_isa_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = NOP
`ifdef INSTR_ENC_STATS_EN
    , parameter int STAT_W = 32
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_kind,
    input  logic [2:0]  in_funct3,
    input  logic        in_alt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    output logic        out_last
`ifdef INSTR_ENC_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_words,
    output logic [15:0]       stat_errs
`endif
);
    li_state_e   state, state_nxt;
    logic [4:0]  pend_rd;
    logic [11:0] pend_lo;
    logic [31:0] pk_word, nxt_instr, li_sum;
    logic        pk_err, nxt_err, nxt_last, load;
    logic        can_load, accept, li_fits, li_split;

    rv_instr_pack u_pack (
        .kind   (in_kind),
        .funct3 (in_funct3),
        .alt    (in_alt),
        .rd     (in_rd),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .imm    (in_imm),
        .word   (pk_word),
        .err    (pk_err)
    );

    assign can_load = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    // +0x800 rounds the upper part so the sign-extended ADDI lands exactly
    assign li_sum   = in_imm + 32'h0000_0800;
    assign li_fits  = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
    assign li_split = (in_kind == K_LI) && !li_fits && (in_imm[11:0] != 12'h0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept && li_split) state_nxt = S_LI_LO;
            S_LI_LO: if (can_load) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = can_load && (state == S_IDLE);
        load      = (state == S_LI_LO) || accept;
        nxt_instr = pk_word;
        nxt_err   = 1'b0;
        nxt_last  = 1'b1;
        if (state == S_LI_LO) begin
            nxt_instr = enc_i(OPC_OP_IMM, pend_rd, 3'b000, pend_rd, pend_lo);
        end else if (pk_err) begin
            nxt_instr = NOP_WORD;
            nxt_err   = 1'b1;
        end else if (in_kind == K_LI) begin
            if (li_fits) begin
                nxt_instr = enc_i(OPC_OP_IMM, in_rd, 3'b000, 5'd0, in_imm[11:0]);
            end else begin
                nxt_instr = enc_u(OPC_LUI, in_rd, li_sum[31:12]);
                nxt_last  = (in_imm[11:0] == 12'h0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_err   <= 1'b0;
            out_last  <= 1'b0;
            pend_rd   <= '0;
            pend_lo   <= '0;
        end else begin
            if (can_load) begin
                out_valid <= load;
                if (load) begin
                    out_instr <= nxt_instr;
                    out_err   <= nxt_err;
                    out_last  <= nxt_last;
                end
            end
            if (accept && li_split) begin
                pend_rd <= in_rd;
                pend_lo <= in_imm[11:0];
            end
        end
    end

`ifdef INSTR_ENC_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_words <= '0;
            stat_errs  <= '0;
        end else if (out_valid && out_ready) begin
            stat_words <= stat_words + STAT_W'(1);
            if (out_err && stat_errs != 16'hFFFF) stat_errs <= stat_errs + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_rv_instr_encoder.sv
// Directed scoreboard bench for rv_instr_encoder: expectations queued at accept,
// compared at each output handshake.
module tb_rv_instr_encoder;
    typedef struct packed {
        logic [31:0] instr;
        logic        err;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_kind = '0;
    logic [2:0]  in_funct3 = '0;
    logic        in_alt = 1'b0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic        out_err, out_last;
`ifdef INSTR_ENC_STATS_EN
    logic [31:0] stat_words;
    logic [15:0] stat_errs;
`endif

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    rv_instr_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_kind   (in_kind),
        .in_funct3 (in_funct3),
        .in_alt    (in_alt),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .out_last  (out_last)
`ifdef INSTR_ENC_STATS_EN
        ,
        .stat_words (stat_words),
        .stat_errs  (stat_errs)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Output-side scoreboard
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("extra_word", out_instr, 32'hxxxx_xxxx);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("instr", out_instr, e.instr);
                chk("err", {31'd0, out_err}, {31'd0, e.err});
                chk("last", {31'd0, out_last}, {31'd0, e.last});
            end
        end
    end

    // Drive one descriptor (called just after a posedge); queue its expected words on accept.
    task automatic send(input logic [3:0] k, input logic [2:0] f3, input logic alt,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic [31:0] w0, input logic e0,
                        input logic l0, input logic two, input logic [31:0] w1);
        bit done = 1'b0;
        in_kind = k; in_funct3 = f3; in_alt = alt;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back('{w0, e0, l0});
                if (two) q.push_back('{w1, 1'b0, 1'b1});
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("send_accept", {31'd0, done}, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (q.size() != 0 || out_valid); i++) begin
            @(posedge clk); #1;
        end
        chk("drain_empty", q.size(), 32'd0);
    endtask

    initial begin
        int c0;
        #12;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_err", {31'd0, out_err}, 32'd0);
        chk("rst_last", {31'd0, out_last}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // R-type ADD / SUB, BEQ legal and out of range
        send(4'd0, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b0, 1'b1, 1'b0, 32'd0);
        send(4'd0, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 32'h402081B3, 1'b0, 1'b1, 1'b0, 32'd0);
        send(4'd4, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h00208463, 1'b0, 1'b1, 1'b0, 32'd0);
        send(4'd4, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd4096, 32'h00000013, 1'b1, 1'b1, 1'b0, 32'd0);
        // SRAI, JAL, SW, LW, and a handful of illegal descriptors
        send(4'd1, 3'b101, 1'b1, 5'd1, 5'd2, 5'd0, 32'd3, 32'h40315093, 1'b0, 1'b1, 1'b0, 32'd0);
        send(4'd5, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h001000EF, 1'b0, 1'b1, 1'b0, 32'd0);
        send(4'd3, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, -32'sd4, 32'hFE20AE23, 1'b0, 1'b1, 1'b0, 32'd0);
        send(4'd1, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0, 32'd2048, 32'h00000013, 1'b1, 1'b1, 1'b0, 32'd0);
        send(4'd7, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'h0010_0000, 32'h00000013, 1'b1, 1'b1, 1'b0, 32'd0);
        send(4'd12, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0, 32'h00000013, 1'b1, 1'b1, 1'b0, 32'd0);

        // LI split into LUI+ADDI; in_ready must drop while the ADDI is pending
        send(4'd9, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345FFF, 32'h123462B7, 1'b0, 1'b0, 1'b1, 32'hFFF28293);
        @(negedge clk);
        chk("li_in_ready_low", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        send(4'd9, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, 1'b0, 1'b1, 1'b0, 32'd0);
        send(4'd9, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFF00293, 1'b0, 1'b1, 1'b0, 32'd0);
        drain();

        // Backpressure: word A stuck in output, descriptor B waits
        out_ready = 1'b0;
        send(4'd2, 3'b010, 1'b0, 5'd5, 5'd1, 5'd0, 32'd16, 32'h0100A283, 1'b0, 1'b1, 1'b0, 32'd0);
        in_kind = 4'd3; in_funct3 = 3'b010; in_rd = 5'd0; in_rs1 = 5'd1; in_rs2 = 5'd2;
        in_imm = -32'sd4; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_hold", out_instr, 32'h0100A283);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(4'd3, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, -32'sd4, 32'hFE20AE23, 1'b0, 1'b1, 1'b0, 32'd0);

        // Full throughput: four descriptors accepted in four cycles
        c0 = cyc;
        send(4'd0, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b0, 1'b1, 1'b0, 32'd0);
        send(4'd0, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 32'h402081B3, 1'b0, 1'b1, 1'b0, 32'd0);
        send(4'd4, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h00208463, 1'b0, 1'b1, 1'b0, 32'd0);
        send(4'd2, 3'b010, 1'b0, 5'd5, 5'd1, 5'd0, 32'd16, 32'h0100A283, 1'b0, 1'b1, 1'b0, 32'd0);
        chk("throughput_cycles", cyc - c0, 32'd4);
        drain();

        // Reset while the ADDI half of an LI is pending
        out_ready = 1'b0;
        send(4'd9, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345FFF, 32'h123462B7, 1'b0, 1'b0, 1'b1, 32'hFFF28293);
        rst_n = 1'b0;
        #1;
        chk("midli_rst_valid", {31'd0, out_valid}, 32'd0);
        q.delete();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(4'd0, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b0, 1'b1, 1'b0, 32'd0);
        drain();
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
